// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Brief    : Requester handshake bundle plus FIFO write-side signals.
// Revision : 1.0
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_en;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_data_in, fifo_wr_en, grant, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_data_in, fifo_wr_en, grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_REQ  = c_PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        c_ST_IDLE  = 1'b0,
        c_ST_BURST = 1'b1
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [NUM_REQ-1:0]   r_grant_q, w_grant_d;
    logic [c_PTR_W-1:0]   r_ptr_q, w_ptr_d;
    logic [c_CNT_W-1:0]   r_beat_cnt_q, w_beat_cnt_d;

    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_any_valid;
    logic [c_PTR_W-1:0]   w_win_idx;
    logic [c_PTR_W-1:0]   w_g_idx;
    int                   w_sum;
    logic                 w_busy;
    logic                 w_g_valid;
    logic                 w_xfer;
    logic [DATA_WIDTH-1:0] w_data;

    // Rotate so bit 0 is the requester at ptr; first set bit wins.
    assign w_rot = {bus.req_valid, bus.req_valid} >> r_ptr_q;

    always_comb begin
        w_any_valid = 1'b0;
        w_win_idx   = '0;
        w_sum       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any_valid && w_rot[k]) begin
                w_any_valid = 1'b1;
                w_sum       = int'(r_ptr_q) + k;
                if (w_sum >= NUM_REQ) begin
                    w_sum = w_sum - NUM_REQ;
                end
                w_win_idx = c_PTR_W'(w_sum);
            end
        end
    end

    always_comb begin
        w_g_idx = '0;
        w_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant_q[k]) begin
                w_g_idx = c_PTR_W'(k);
                w_data  = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_busy    = (r_state_q == c_ST_BURST);
    assign w_g_valid = |(bus.req_valid & r_grant_q);
    // Reset gates the handshake combinationally so nothing is accepted mid-reset.
    assign w_xfer    = w_busy & w_g_valid & ~bus.fifo_full & ~rst;

    assign bus.req_ready    = (w_busy && !bus.fifo_full && !rst) ? r_grant_q : '0;
    assign bus.fifo_wr_en   = w_xfer;
    assign bus.fifo_data_in = w_data;
    assign bus.grant        = r_grant_q;
    assign bus.busy         = w_busy;

    always_comb begin
        w_state_d    = r_state_q;
        w_grant_d    = r_grant_q;
        w_ptr_d      = r_ptr_q;
        w_beat_cnt_d = r_beat_cnt_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_d    = c_ST_BURST;
                    w_grant_d    = NUM_REQ'(1) << w_win_idx;
                    w_beat_cnt_d = '0;
                end
            end
            c_ST_BURST: begin
                if ((w_xfer && (r_beat_cnt_q == c_LAST_BEAT)) || !w_g_valid) begin
                    w_state_d    = c_ST_IDLE;
                    w_grant_d    = '0;
                    w_beat_cnt_d = '0;
                    w_ptr_d      = (w_g_idx == c_LAST_REQ) ? '0 : w_g_idx + 1'b1;
                end else if (w_xfer) begin
                    w_beat_cnt_d = r_beat_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_IDLE;
            r_grant_q    <= '0;
            r_ptr_q      <= '0;
            r_beat_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_grant_q    <= w_grant_d;
            r_ptr_q      <= w_ptr_d;
            r_beat_cnt_q <= w_beat_cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed + random bench for fifo_wr_arbiter against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;
    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Requester sources: each holds a list of beats; valid = pending & enabled.
    logic [DW-1:0] src_mem [NR][DEPTH];
    int            head [NR];
    int            tail [NR];
    logic [NR-1:0] en_v;
    logic          full_v;
    logic          rst_v;

    // Reference model state (plain integers)
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_beats;

    logic [DW-1:0] act_q [$];
    logic [DW-1:0] exp_q [$];
    logic [NR-1:0] gnt_log [$];
    logic [NR-1:0] prev_grant;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [DW-1:0] d);
        if (tail[r] < DEPTH) begin
            src_mem[r][tail[r]] = d;
            tail[r]++;
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NR; i++) s += tail[i] - head[i];
        return s;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_g     = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic end_burst();
        m_busy  = 1'b0;
        m_ptr   = (m_g + 1) % NR;
        m_beats = 0;
    endtask

    // One clock: drive at negedge, check before posedge, advance model at posedge.
    task automatic cycle();
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    e_gnt, e_rdy, hs;
        logic             e_wr;
        logic [DW-1:0]    e_data;
        bit               found;
        int               idx;
        for (int i = 0; i < NR; i++) begin
            v[i] = en_v[i] && (head[i] < tail[i]);
            d[i*DW +: DW] = v[i] ? src_mem[i][head[i]] : DW'($urandom);
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_full = full_v;
        rst           = rst_v;
        #1;
        e_gnt  = m_busy ? (NR'(1) << m_g) : '0;
        e_rdy  = (m_busy && !rst_v && !full_v) ? e_gnt : '0;
        e_wr   = m_busy && v[m_g] && !full_v && !rst_v;
        e_data = m_busy ? d[m_g*DW +: DW] : '0;
        chk("busy",      32'(bus.busy),         32'(m_busy));
        chk("grant",     32'(bus.grant),        32'(e_gnt));
        chk("req_ready", 32'(bus.req_ready),    32'(e_rdy));
        chk("wr_en",     32'(bus.fifo_wr_en),   32'(e_wr));
        chk("data_in",   32'(bus.fifo_data_in), 32'(e_data));
        if (bus.grant != '0 && prev_grant == '0) gnt_log.push_back(bus.grant);
        prev_grant = bus.grant;
        if (bus.fifo_wr_en === 1'b1) act_q.push_back(bus.fifo_data_in);
        hs = v & bus.req_ready;
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (hs[i] === 1'b1) head[i]++;
        if (rst_v) begin
            model_reset();
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (!found && v[idx]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_g     = idx;
                    m_beats = 0;
                end
            end
        end else if (e_wr) begin
            exp_q.push_back(e_data);
            m_beats++;
            if (m_beats == MB) end_burst();
        end else if (!v[m_g]) begin
            end_burst();
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int budget = 0;
        en_v   = '1;
        full_v = 1'b0;
        rst_v  = 1'b0;
        while ((pending() > 0 || m_busy) && budget < 400) begin
            cycle();
            budget++;
        end
        chk("drain_pending", 32'(pending()), 32'd0);
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_len"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk({tag, "_beat"}, 32'(act_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_logs();
        act_q.delete();
        exp_q.delete();
        gnt_log.delete();
    endtask

    task automatic chk_grants(input string tag, input logic [NR-1:0] g [$]);
        chk({tag, "_ngrant"}, 32'(gnt_log.size()), 32'(g.size()));
        for (int i = 0; i < gnt_log.size() && i < g.size(); i++)
            chk({tag, "_grant"}, 32'(gnt_log[i]), 32'(g[i]));
    endtask

    initial begin
        logic [NR-1:0] eg [$];
        logic [DW-1:0] ed [$];
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        model_reset();
        prev_grant     = '0;
        en_v           = '1;
        full_v         = 1'b0;
        rst_v          = 1'b1;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.fifo_full  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycle();                       // outputs checked while held in reset
        rst_v = 1'b0;

        // Test 1: req 0 alone, six beats -> bursts of 4 and 2
        for (int k = 1; k <= 6; k++) push(0, DW'(k));
        run(10);
        chk("t1_nwrites", 32'(act_q.size()), 32'd6);
        for (int i = 0; i < act_q.size() && i < 6; i++) chk("t1_data", 32'(act_q[i]), 32'(i + 1));
        eg = '{4'b0001, 4'b0001};
        chk_grants("t1", eg);
        compare_logs("t1");
        clear_logs();

        // Test 2: all requesters busy from a fresh reset
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        clear_logs();
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 4; b++) push(i, DW'(8'h10 * i + b));
        for (int b = 4; b < 8; b++) push(0, DW'(b));
        run(26);
        ed.delete();
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 4; b++) ed.push_back(DW'(8'h10 * i + b));
        for (int b = 4; b < 8; b++) ed.push_back(DW'(b));
        chk("t2_nwrites", 32'(act_q.size()), 32'(ed.size()));
        for (int i = 0; i < act_q.size() && i < ed.size(); i++) chk("t2_data", 32'(act_q[i]), 32'(ed[i]));
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk_grants("t2", eg);
        compare_logs("t2");
        clear_logs();

        // Test 3: req 2 stalled by fifo_full for three cycles after two beats
        for (int b = 0; b < 4; b++) push(2, DW'(8'hA0 + b));
        run(3);
        full_v = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("t3_stall_ready", 32'(bus.req_ready), 32'd0);
        end
        full_v = 1'b0;
        run(4);
        chk("t3_nwrites", 32'(act_q.size()), 32'd4);
        for (int i = 0; i < act_q.size() && i < 4; i++) chk("t3_data", 32'(act_q[i]), 32'(8'hA0 + i));
        compare_logs("t3");
        clear_logs();

        // Test 4: req 1 drops valid after two beats; then reqs 0 and 3 from ptr 2
        push(1, 8'hB0);
        push(1, 8'hB1);
        run(3);
        for (int b = 0; b < 4; b++) begin
            push(0, DW'(8'hC0 + b));
            push(3, DW'(8'hD0 + b));
        end
        drain();
        eg = '{4'b0010, 4'b1000, 4'b0001};
        chk_grants("t4", eg);
        compare_logs("t4");
        clear_logs();

        // Test 5: reset during the third beat of req 1's burst
        for (int b = 0; b < 6; b++) push(1, DW'(8'hE0 + b));
        for (int b = 0; b < 4; b++) push(2, DW'(8'hF0 + b));
        run(3);
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        #1;
        chk("t5_busy_after_rst",  32'(bus.busy),  32'd0);
        chk("t5_grant_after_rst", 32'(bus.grant), 32'd0);
        drain();
        eg = '{4'b0010, 4'b0010, 4'b0100};
        chk_grants("t5", eg);
        compare_logs("t5");
        clear_logs();

        // Test 6: reqs 1 and 3 with ptr at 2
        push(1, 8'h55);
        run(3);
        for (int b = 0; b < 4; b++) begin
            push(1, DW'(8'h60 + b));
            push(3, DW'(8'h70 + b));
        end
        drain();
        eg = '{4'b0010, 4'b1000, 4'b0010};
        chk_grants("t6", eg);
        compare_logs("t6");
        clear_logs();

        // Random traffic, back-pressure and occasional reset
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(3) == 0) push($urandom_range(NR - 1), DW'($urandom));
            for (int i = 0; i < NR; i++) en_v[i] = ($urandom_range(3) != 0);
            full_v = ($urandom_range(4) == 0);
            rst_v  = ($urandom_range(99) == 0);
            cycle();
        end
        drain();
        compare_logs("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
